// File: rtl/udma_rx_channel.sv
// uDMA RX channel: moves peripheral RX beats into aligned L2 word writes and
// tracks the programmed transfer (address, bytes left, pending/continuous reload).
module udma_rx_channel #(
    parameter int L2_WIDTH_NOAL = 19,
    parameter int TRANS_SIZE    = 20,
    parameter int DATA_SIZE     = 32
) (
    input  logic                     sys_clk_i,
    input  logic                     rstn_i,
    input  logic [L2_WIDTH_NOAL-1:0] cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0]    cfg_size_i,
    input  logic                     cfg_continuous_i,
    input  logic                     cfg_en_i,
    input  logic                     cfg_clr_i,
    output logic                     cfg_en_o,
    output logic                     cfg_pending_o,
    output logic [L2_WIDTH_NOAL-1:0] cfg_curr_addr_o,
    output logic [TRANS_SIZE-1:0]    cfg_bytes_left_o,
    input  logic [DATA_SIZE-1:0]     data_i,
    input  logic [1:0]               data_datasize_i,
    input  logic                     data_valid_i,
    output logic                     data_ready_o,
    output logic                     l2_req_o,
    input  logic                     l2_gnt_i,
    output logic [L2_WIDTH_NOAL-1:0] l2_addr_o,
    output logic [31:0]              l2_wdata_o,
    output logic [3:0]               l2_be_o,
    output logic                     eot_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state, state_next;
    logic [L2_WIDTH_NOAL-1:0] curr_addr, start_addr, pend_addr, wr_addr;
    logic [TRANS_SIZE-1:0]    bytes_left, start_size, pend_size;
    logic                     continuous, pend_cont, pend_valid;
    logic                     buf_valid, orphan, eot;
    logic [31:0]              wr_data;
    logic [3:0]               wr_be;
    logic [2:0]               wr_nbytes, beat_nbytes;

    logic beat_fire, gnt_fire, status_gnt, last_gnt;
    logic en_ok, start_idle, en_run;

    function automatic logic [2:0] size_bytes(input logic [1:0] ds);
        case (ds)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] n, input logic [1:0] off);
        logic [7:0] mask;
        mask = (8'd1 << n) - 8'd1;
        mask = mask << off;
        return mask[3:0];
    endfunction

    always_comb begin
        beat_nbytes = size_bytes(data_datasize_i);
        if (bytes_left < TRANS_SIZE'(beat_nbytes))
            beat_nbytes = bytes_left[2:0];
    end

    // Orphaned writes (left over from an abort) retire without touching status.
    always_comb begin
        beat_fire  = data_valid_i & data_ready_o & ~cfg_clr_i;
        gnt_fire   = buf_valid & l2_gnt_i;
        status_gnt = gnt_fire & ~orphan & ~cfg_clr_i;
        last_gnt   = status_gnt & (bytes_left == TRANS_SIZE'(wr_nbytes));
        en_ok      = cfg_en_i & ~cfg_clr_i & (cfg_size_i != '0);
        start_idle = en_ok & (state == IDLE);
        en_run     = en_ok & (state == RUN) & ~pend_valid;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_idle) state_next = RUN;
            RUN: begin
                if (cfg_clr_i)
                    state_next = IDLE;
                else if (last_gnt & ~pend_valid & ~en_run & ~continuous)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            curr_addr  <= '0;
            start_addr <= '0;
            pend_addr  <= '0;
            bytes_left <= '0;
            start_size <= '0;
            pend_size  <= '0;
            continuous <= 1'b0;
            pend_cont  <= 1'b0;
            pend_valid <= 1'b0;
            buf_valid  <= 1'b0;
            orphan     <= 1'b0;
            eot        <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_be      <= '0;
            wr_nbytes  <= '0;
        end else begin
            eot <= last_gnt;

            if (beat_fire) begin
                buf_valid <= 1'b1;
                wr_addr   <= {curr_addr[L2_WIDTH_NOAL-1:2], 2'b00};
                wr_data   <= data_i << {curr_addr[1:0], 3'b000};
                wr_be     <= byte_en(beat_nbytes, curr_addr[1:0]);
                wr_nbytes <= beat_nbytes;
            end
            if (gnt_fire) begin
                buf_valid <= 1'b0;
                orphan    <= 1'b0;
            end
            if (status_gnt) begin
                curr_addr  <= curr_addr + L2_WIDTH_NOAL'(wr_nbytes);
                bytes_left <= bytes_left - TRANS_SIZE'(wr_nbytes);
            end

            // Transfer bookkeeping; later assignments override the grant update above.
            if (cfg_clr_i) begin
                pend_valid <= 1'b0;
                bytes_left <= '0;
                if (buf_valid & ~l2_gnt_i) orphan <= 1'b1;
            end else if (start_idle) begin
                curr_addr  <= cfg_startaddr_i;
                start_addr <= cfg_startaddr_i;
                bytes_left <= cfg_size_i;
                start_size <= cfg_size_i;
                continuous <= cfg_continuous_i;
            end else if (last_gnt) begin
                if (pend_valid) begin
                    curr_addr  <= pend_addr;
                    start_addr <= pend_addr;
                    bytes_left <= pend_size;
                    start_size <= pend_size;
                    continuous <= pend_cont;
                    pend_valid <= 1'b0;
                end else if (en_run) begin
                    curr_addr  <= cfg_startaddr_i;
                    start_addr <= cfg_startaddr_i;
                    bytes_left <= cfg_size_i;
                    start_size <= cfg_size_i;
                    continuous <= cfg_continuous_i;
                end else if (continuous) begin
                    curr_addr  <= start_addr;
                    bytes_left <= start_size;
                end
            end else if (en_run) begin
                pend_valid <= 1'b1;
                pend_addr  <= cfg_startaddr_i;
                pend_size  <= cfg_size_i;
                pend_cont  <= cfg_continuous_i;
            end
        end
    end

    assign cfg_en_o         = (state == RUN);
    assign cfg_pending_o    = pend_valid;
    assign cfg_curr_addr_o  = curr_addr;
    assign cfg_bytes_left_o = bytes_left;
    assign data_ready_o     = (state == RUN) & ~buf_valid;
    assign l2_req_o         = buf_valid;
    assign l2_addr_o        = wr_addr;
    assign l2_wdata_o       = wr_data;
    assign l2_be_o          = wr_be;
    assign eot_o            = eot;

endmodule
